// File: rtl/ff_mode_bank.sv
// WIDTH-bit bank of flip-flops whose shared function (SR/JK/D/T) is chosen by mode.
// Define FF_MODE_BANK_ERR_STICKY_EN to keep err set until clr or rst.
module ff_mode_bank #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] err_mask,
    output logic             err
);

    typedef enum logic [1:0] {
        ModeSr = 2'b00,
        ModeJk = 2'b01,
        ModeD  = 2'b10,
        ModeT  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qbar_q, qbar_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] jk_next;
    logic [WIDTH-1:0] both_high;
    logic             sr_hit;

    // S=R=1 is neither a set nor a reset, so q holds for those bits.
    assign both_high = a & b;
    assign sr_next   = (q_q | (a & ~b)) & ~(~a & b);
    assign jk_next   = (a & ~q_q) | (~b & q_q);

    always_comb begin
        q_d    = q_q;
        mask_d = mask_q;
        err_d  = err_q;
        sr_hit = 1'b0;
        if (clr) begin
            q_d    = '0;
            mask_d = '0;
            err_d  = 1'b0;
        end else if (en) begin
            mask_d = '0;
            unique case (mode_e'(mode))
                ModeSr: begin
                    q_d    = sr_next;
                    mask_d = both_high;
                    sr_hit = |both_high;
                end
                ModeJk: q_d = jk_next;
                ModeD:  q_d = a;
                ModeT:  q_d = q_q ^ a;
                default: q_d = q_q;
            endcase
`ifdef FF_MODE_BANK_ERR_STICKY_EN
            err_d = err_q | sr_hit;
`else
            err_d = sr_hit;
`endif
        end
        qbar_d = ~q_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            qbar_q <= '1;
            mask_q <= '0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            qbar_q <= qbar_d;
            mask_q <= mask_d;
            err_q  <= err_d;
        end
    end

    assign q        = q_q;
    assign qbar     = qbar_q;
    assign err_mask = mask_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ff_mode_bank.sv
// Self-checking bench for ff_mode_bank (WIDTH=4): vector table plus reset corner cases.
module tb_ff_mode_bank;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   mode;
    logic         en;
    logic         clr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic [W-1:0] err_mask;
    logic         err;

    ff_mode_bank #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .en       (en),
        .clr      (clr),
        .a        (a),
        .b        (b),
        .q        (q),
        .qbar     (qbar),
        .err_mask (err_mask),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       clr;
        logic       en;
        logic [1:0] mode;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] mask;
        logic       err_ns;
        logic       err_st;
    } vec_t;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] qbar;
        logic [3:0] mask;
        logic       err;
    } exp_t;

    localparam logic [1:0] SR = 2'b00, JK = 2'b01, DM = 2'b10, TM = 2'b11;

    exp_t sb[$];
    vec_t tbl[19];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic e, input logic [1:0] m,
                         input logic [3:0] va, input logic [3:0] vb);
        clr  = c;
        en   = e;
        mode = m;
        a    = va;
        b    = vb;
    endtask

    task automatic push_exp(input logic [3:0] eq, input logic [3:0] em, input logic ens,
                            input logic est);
        exp_t x;
        x.q    = eq;
        x.qbar = ~eq;
        x.mask = em;
`ifdef FF_MODE_BANK_ERR_STICKY_EN
        x.err  = est;
`else
        x.err  = ens;
`endif
        sb.push_back(x);
    endtask

    task automatic compare(input int idx);
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty[%0d] got 0 entries expected 1", idx);
        end else begin
            x = sb.pop_front();
            check("q", idx, q, x.q);
            check("qbar", idx, qbar, x.qbar);
            check("err_mask", idx, err_mask, x.mask);
            check("err", idx, {3'b000, err}, {3'b000, x.err});
        end
    endtask

    initial begin
        //           clr  en   mode a        b        q        mask     ns    st
        tbl[0]  = '{1'b0, 1'b1, SR, 4'b1100, 4'b0110, 4'b1000, 4'b0100, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, SR, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, SR, 4'b0001, 4'b0001, 4'b1000, 4'b0001, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, SR, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, SR, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, DM, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, DM, 4'b0101, 4'b1111, 4'b0101, 4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, JK, 4'b1111, 4'b1111, 4'b1010, 4'b0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, JK, 4'b1111, 4'b1111, 4'b0101, 4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, JK, 4'b1111, 4'b1111, 4'b1010, 4'b0000, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, DM, 4'b0110, 4'b0000, 4'b0110, 4'b0000, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, TM, 4'b0011, 4'b1111, 4'b0101, 4'b0000, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, TM, 4'b1111, 4'b1111, 4'b0101, 4'b0000, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, JK, 4'b1100, 4'b1010, 4'b1101, 4'b0000, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, SR, 4'b1011, 4'b1011, 4'b1101, 4'b1011, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 1'b0, SR, 4'b0000, 4'b0000, 4'b1101, 4'b1011, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 1'b1, TM, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b1, SR, 4'b0101, 4'b0010, 4'b0101, 4'b0000, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 1'b0, SR, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0};

        rst = 1'b1;
        drive(1'b0, 1'b0, SR, 4'b0000, 4'b0000);
        #12;
        check("rst_q", 0, q, 4'b0000);
        check("rst_qbar", 0, qbar, 4'b1111);
        check("rst_mask", 0, err_mask, 4'b0000);
        check("rst_err", 0, {3'b000, err}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(tbl[i].clr, tbl[i].en, tbl[i].mode, tbl[i].a, tbl[i].b);
            push_exp(tbl[i].q, tbl[i].mask, tbl[i].err_ns, tbl[i].err_st);
            @(posedge clk);
            #1;
            compare(i);
        end

        // Load q=1010 with err set, then pulse rst between edges.
        @(negedge clk);
        drive(1'b0, 1'b1, DM, 4'b1010, 4'b0000);
        push_exp(4'b1010, 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        compare(100);
        @(negedge clk);
        drive(1'b0, 1'b1, SR, 4'b0001, 4'b0001);
        push_exp(4'b1010, 4'b0001, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        compare(101);
        #2;
        rst = 1'b1;
        #1;
        check("async_q", 102, q, 4'b0000);
        check("async_qbar", 102, qbar, 4'b1111);
        check("async_mask", 102, err_mask, 4'b0000);
        check("async_err", 102, {3'b000, err}, 4'b0000);

        // Edge while rst held: update must be discarded.
        @(negedge clk);
        drive(1'b0, 1'b1, DM, 4'b1111, 4'b0000);
        @(posedge clk);
        #1;
        check("held_q", 103, q, 4'b0000);
        check("held_qbar", 103, qbar, 4'b1111);

        // First edge after release applies normally.
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, DM, 4'b0011, 4'b0000);
        push_exp(4'b0011, 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        compare(104);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
